// File: rtl/sdio_cmd_host.sv
// sdio_cmd_host: host SD/SDIO CMD-line engine (48-bit command TX, 48/136-bit response RX).
// Define SDIO_RESP_CRC_CHECK_EN to build the response CRC7 / end-bit checker.
`timescale 1ns/1ps
`default_nettype none

module sdio_cmd_host #(
  parameter int CMD_SIZE  = 48,
  parameter int RESP_SIZE = 136,
  parameter int MAXLAT    = 64,
  parameter int TURN_CYC  = 2
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 sd_en,
  input  logic                 start,
  input  logic [5:0]           cmd_idx,
  input  logic [31:0]          cmd_arg,
  input  logic [1:0]           resp_type,
  input  logic                 cmd_i,
  output logic                 cmd_o,
  output logic                 cmd_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [RESP_SIZE-1:0] resp_o,
  output logic                 crc_err
);

  localparam int R1_SIZE = 48;
  localparam int CNT_MAX = (RESP_SIZE > MAXLAT) ? RESP_SIZE : MAXLAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_TURN, S_WAIT_RESP, S_RECV, S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc, rx_len;
  logic [CMD_SIZE-1:0]  tx_q, tx_d;
  logic [RESP_SIZE-1:0] rx_q, rx_d, resp_q, resp_d;
  logic [1:0]           rtype_q, rtype_d;
  logic                 timeout_q, timeout_d;
  logic                 cmd_q;
`ifdef SDIO_RESP_CRC_CHECK_EN
  logic                 crc_err_q, crc_err_d;
  logic [6:0]           rcrc_q, rcrc_d;
  logic [CNT_W-1:0]     crc_lo;
`endif

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign rx_len  = (rtype_q == 2'd2) ? CNT_W'(RESP_SIZE) : CNT_W'(R1_SIZE);
`ifdef SDIO_RESP_CRC_CHECK_EN
  // R2 CRC excludes the 8-bit header; R1 header start bit is 0 and leaves CRC at 0
  assign crc_lo  = (rtype_q == 2'd2) ? CNT_W'(9) : CNT_W'(2);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    rtype_d   = rtype_q;
    timeout_d = timeout_q;
`ifdef SDIO_RESP_CRC_CHECK_EN
    crc_err_d = crc_err_q;
    rcrc_d    = rcrc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d = CMD_SIZE'({2'b01, cmd_idx, cmd_arg,
                            crc7_40({2'b01, cmd_idx, cmd_arg}), 1'b1});
          rtype_d   = resp_type;
          cnt_d     = '0;
          timeout_d = 1'b0;
`ifdef SDIO_RESP_CRC_CHECK_EN
          crc_err_d = 1'b0;
`endif
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        tx_d  = {tx_q[CMD_SIZE-2:0], 1'b1};
        cnt_d = cnt_inc;
        if (cnt_q == CNT_W'(CMD_SIZE - 1)) begin
          cnt_d   = '0;
          state_d = (rtype_q == 2'd0) ? S_FINISH : S_TURN;
        end
      end
      S_TURN: begin
        if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_RESP: begin
        if (!cmd_q) begin
          rx_d    = '0;
          cnt_d   = CNT_W'(1);
`ifdef SDIO_RESP_CRC_CHECK_EN
          rcrc_d  = '0;
`endif
          state_d = S_RECV;
        end else if (cnt_q == CNT_W'(MAXLAT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RECV: begin
        rx_d  = {rx_q[RESP_SIZE-2:0], cmd_q};
        cnt_d = cnt_inc;
`ifdef SDIO_RESP_CRC_CHECK_EN
        if (cnt_inc >= crc_lo && cnt_inc <= rx_len - CNT_W'(8))
          rcrc_d = crc7_step(rcrc_q, cmd_q);
`endif
        if (cnt_inc == rx_len) begin
          resp_d  = rx_d;
          state_d = S_FINISH;
`ifdef SDIO_RESP_CRC_CHECK_EN
          crc_err_d = ~rx_d[0] | ((rtype_q != 2'd3) && (rcrc_q != rx_d[7:1]));
`endif
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Disable aborts silently: straight to IDLE, no done pulse
    if (!sd_en) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      resp_d    = '0;
      timeout_d = 1'b0;
`ifdef SDIO_RESP_CRC_CHECK_EN
      crc_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      resp_q    <= '0;
      rtype_q   <= 2'd0;
      timeout_q <= 1'b0;
      cmd_q     <= 1'b1;
`ifdef SDIO_RESP_CRC_CHECK_EN
      crc_err_q <= 1'b0;
      rcrc_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      rtype_q   <= rtype_d;
      timeout_q <= timeout_d;
      cmd_q     <= cmd_i;
`ifdef SDIO_RESP_CRC_CHECK_EN
      crc_err_q <= crc_err_d;
      rcrc_q    <= rcrc_d;
`endif
    end
  end

  assign cmd_oe  = (state_q == S_SEND);
  assign cmd_o   = (state_q == S_SEND) ? tx_q[CMD_SIZE-1] : 1'b1;
  assign busy    = (state_q == S_SEND) || (state_q == S_TURN) ||
                   (state_q == S_WAIT_RESP) || (state_q == S_RECV);
  assign done    = (state_q == S_FINISH);
  assign timeout = timeout_q;
  assign resp_o  = resp_q;
`ifdef SDIO_RESP_CRC_CHECK_EN
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdio_cmd_host.sv
// tb_sdio_cmd_host: randomized self-checking bench for sdio_cmd_host with a behavioural card/host model.
`timescale 1ns/1ps
`default_nettype none

module tb_sdio_cmd_host;

  localparam int CMD_SIZE  = 48;
  localparam int RESP_SIZE = 136;
  localparam int MAXLAT    = 64;
  localparam int TURN_CYC  = 2;
  // Idle cycles the card may wait after release and still be heard:
  // TURN_CYC released cycles, one input register stage, MAXLAT search window.
  localparam int N_MIN = TURN_CYC - 1;
  localparam int N_MAX = TURN_CYC + MAXLAT - 2;
`ifdef SDIO_RESP_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic                 sd_clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sd_en = 1'b0;
  logic                 start = 1'b0;
  logic [5:0]           cmd_idx = '0;
  logic [31:0]          cmd_arg = '0;
  logic [1:0]           resp_type = '0;
  logic                 cmd_i = 1'b1;
  logic                 cmd_o, cmd_oe, busy, done, timeout, crc_err;
  logic [RESP_SIZE-1:0] resp_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [135:0] model_resp = '0;
  logic [47:0]  last_frame = '0;

  always #5 sd_clk = ~sd_clk;

  sdio_cmd_host #(
    .CMD_SIZE (CMD_SIZE),
    .RESP_SIZE(RESP_SIZE),
    .MAXLAT   (MAXLAT),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .sd_en    (sd_en),
    .start    (start),
    .cmd_idx  (cmd_idx),
    .cmd_arg  (cmd_arg),
    .resp_type(resp_type),
    .cmd_i    (cmd_i),
    .cmd_o    (cmd_o),
    .cmd_oe   (cmd_oe),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .resp_o   (resp_o),
    .crc_err  (crc_err)
  );

  task automatic chk_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sd_clk);
    #1;
  endtask

  // CRC7 as polynomial long division of msg*x^7 by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [127:0] msg, input int n);
    logic [134:0] v;
    v = {7'd0, msg} << 7;
    for (int i = n + 6; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk_r1(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b00, idx, arg};
    return {h, ref_crc7({88'd0, h}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk_r2(input logic [119:0] body);
    return {8'h3F, body, ref_crc7({8'd0, body}, 120), 1'b1};
  endfunction

  function automatic logic exp_crc_err(input logic [1:0] rt, input logic [135:0] r);
    logic bad_crc;
    if (rt == 2'd2) bad_crc = (ref_crc7({8'd0, r[127:8]}, 120) != r[7:1]);
    else            bad_crc = (ref_crc7({88'd0, r[47:8]}, 40) != r[7:1]);
    return CRC_CHK && (!r[0] || (rt != 2'd3 && bad_crc));
  endfunction

  // n_idle < 0: no card, CMD line stays high
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input int n_idle, input logic [135:0] rbits);
    logic [47:0]  frame, exp_frame;
    logic [39:0]  h;
    logic [135:0] r_obs;
    logic         to_obs, ce_obs, bz_obs;
    bit           q[$];
    bit           acc, card;
    int           oe_n, len, budget, j, done_n, done_at, exp_at;
    h = {2'b01, idx, arg};
    exp_frame = {h, ref_crc7({88'd0, h}, 40), 1'b1};
    cmd_idx = idx; cmd_arg = arg; resp_type = rt; start = 1'b1;
    tick;
    start = 1'b0;
    chk_val({tag, ":busy_acc"}, busy, 1);
    frame = '0; oe_n = 0;
    for (int i = 0; i < CMD_SIZE; i++) begin
      frame = {frame[46:0], cmd_o};
      if (cmd_oe) oe_n++;
      if (i == 10) begin start = 1'b1; cmd_idx = ~idx; end
      if (i == 11) begin start = 1'b0; cmd_idx = idx; end
      tick;
    end
    last_frame = frame;
    chk_val({tag, ":frame"}, frame, exp_frame);
    chk_val({tag, ":oe_cycles"}, oe_n, CMD_SIZE);
    chk_val({tag, ":oe_release"}, cmd_oe, 0);
    if (rt == 2'd0) begin
      chk_val({tag, ":done"}, done, 1);
      chk_val({tag, ":busy_done"}, busy, 0);
      chk_val({tag, ":timeout"}, timeout, 0);
      tick;
      chk_val({tag, ":done_once"}, done, 0);
      return;
    end
    len  = (rt == 2'd2) ? 136 : 48;
    card = (n_idle >= 0);
    acc  = card && n_idle >= N_MIN && n_idle <= N_MAX;
    if (card) begin
      for (int i = 0; i < n_idle; i++) q.push_back(1'b1);
      for (int b = len - 1; b >= 0; b--) q.push_back(rbits[b]);
    end
    budget = (card ? n_idle + len : 0) + MAXLAT + TURN_CYC + 8;
    exp_at = acc ? n_idle + len + 1 : TURN_CYC + MAXLAT;
    done_n = 0; done_at = 0; j = 0;
    to_obs = 1'bx; ce_obs = 1'bx; bz_obs = 1'bx; r_obs = 'x;
    while (j < budget && (done_n == 0 || q.size() > 0)) begin
      cmd_i = (q.size() > 0) ? q.pop_front() : 1'b1;
      tick;
      j++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = j; to_obs = timeout; ce_obs = crc_err; r_obs = resp_o; bz_obs = busy;
        end
      end
    end
    cmd_i = 1'b1;
    tick;
    if (done) done_n++;
    chk_val({tag, ":done_count"}, done_n, 1);
    chk_val({tag, ":done_cycle"}, done_at, exp_at);
    chk_val({tag, ":busy_done"}, bz_obs, 0);
    chk_val({tag, ":timeout"}, to_obs, acc ? 1'b0 : 1'b1);
    chk_val({tag, ":resp"}, r_obs, acc ? rbits : model_resp);
    chk_val({tag, ":crc_err"}, ce_obs, acc ? exp_crc_err(rt, rbits) : 1'b0);
    if (acc) model_resp = rbits;
  endtask

  task automatic abort_test(input string tag, input bit use_rst);
    int dn;
    cmd_idx = 6'd17; cmd_arg = $urandom; resp_type = 2'd1; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    if (use_rst) begin
      #2 rst = 1'b1;
      #1;
    end else begin
      sd_en = 1'b0;
      tick;
    end
    chk_val({tag, ":oe"}, cmd_oe, 0);
    chk_val({tag, ":cmd_o"}, cmd_o, 1);
    chk_val({tag, ":busy"}, busy, 0);
    chk_val({tag, ":resp_clr"}, resp_o, 0);
    model_resp = '0;
    if (use_rst) begin
      @(posedge sd_clk);
      #1 rst = 1'b0;
    end else begin
      sd_en = 1'b1;
    end
    dn = 0;
    repeat (80) begin
      tick;
      if (done) dn++;
    end
    chk_val({tag, ":no_done"}, dn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    logic [119:0] body;
    logic [135:0] rb;
    int           n;

    #3;
    chk_val("rst:cmd_o", cmd_o, 1);
    chk_val("rst:cmd_oe", cmd_oe, 0);
    chk_val("rst:busy", busy, 0);
    chk_val("rst:done", done, 0);
    chk_val("rst:timeout", timeout, 0);
    chk_val("rst:resp", resp_o, 0);
    chk_val("rst:crc_err", crc_err, 0);
    @(posedge sd_clk);
    #1 rst = 1'b0;
    sd_en = 1'b1;
    tick;

    run_cmd("cmd0", 6'd0, 32'h0, 2'd0, 0, '0);
    chk_val("cmd0:literal", last_frame, 48'h400000000095);
    run_cmd("cmd8", 6'd8, 32'h1AA, 2'd1, 5, {88'd0, 48'h08000001AA13});
    chk_val("cmd8:crc_byte", last_frame[7:0], 8'h87);
    body = {$urandom, $urandom, $urandom, 24'($urandom)};
    run_cmd("cmd2", 6'd2, 32'h0, 2'd2, 10, mk_r2(body));
    run_cmd("cmd17_to", 6'd17, 32'h1000, 2'd1, -1, '0);
    run_cmd("lat_max", 6'd9, 32'h5A5A0000, 2'd1, N_MAX, {88'd0, mk_r1(6'd9, 32'h12345678)});
    run_cmd("lat_over", 6'd9, 32'h5A5A0000, 2'd1, N_MAX + 1, {88'd0, mk_r1(6'd9, 32'h1)});
    rb = {88'd0, mk_r1(6'h3F, 32'h80FF8000)};
    rb[7:1] = 7'h7F;
    run_cmd("lat_min_r3", 6'd41, 32'h40FF8000, 2'd3, N_MIN, rb);
    run_cmd("cmd8_bad", 6'd8, 32'h1AA, 2'd1, 5, {88'd0, 48'h08000001AA15});

    abort_test("abort_rst", 1'b1);
    run_cmd("clean1", 6'd8, 32'h1AA, 2'd1, 3, {88'd0, 48'h08000001AA13});
    abort_test("abort_en", 1'b0);
    run_cmd("clean2", 6'd0, 32'h0, 2'd0, 0, '0);

    for (int it = 0; it < 12; it++) begin
      idx = 6'($urandom);
      arg = $urandom;
      rt  = 2'($urandom_range(0, 3));
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(N_MAX + 1, N_MAX + 4))
                                         : int'($urandom_range(N_MIN, N_MAX));
      if (rt == 2'd2) begin
        body = {$urandom, $urandom, $urandom, 24'($urandom)};
        rb   = mk_r2(body);
      end else begin
        rb = {88'd0, mk_r1(idx, arg)};
        if (rt == 2'd3) rb[7:1] = 7'h7F;
      end
      case ($urandom_range(0, 3))
        0:       rb[3] = ~rb[3];
        1:       rb[0] = 1'b0;
        default: ;
      endcase
      run_cmd("rnd", idx, arg, rt, n, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdio_cmd_host.md
Name: sdio_cmd_host

Overview:
- Host-side SD/SDIO CMD-line engine: the initiator for the bus our CMD capture logic observes.
- On a start request it serialises one 48-bit command frame (start, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit) onto the CMD line.
- It then releases the line and, when the command expects one, waits for and captures the 48-bit or 136-bit card response.
- Sits between the controller's command sequencer and the CMD pad (cmd_o/cmd_oe/cmd_i).

Parameters:
- CMD_SIZE, 48, command frame length in bits.
- RESP_SIZE, 136, long (R2) response length in bits; width of resp_o.
- MAXLAT, 64, max sd_clk cycles after turnaround to wait for a response start bit (N_CR limit).
- TURN_CYC, 2, cycles CMD is released before the response search begins.

Ports:
- sd_clk, input, 1, bus clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- sd_en, input, 1, synchronous enable; low forces IDLE.
- start, input, 1, issue-command request; sampled only in IDLE.
- cmd_idx, input, 6, command index.
- cmd_arg, input, 32, command argument.
- resp_type, input, 2, 0 = no response, 1 = 48-bit, 2 = 136-bit, 3 treated as 1.
- cmd_i, input, 1, CMD pad input.
- cmd_o, output, 1, CMD pad output value.
- cmd_oe, output, 1, CMD pad output enable.
- busy, output, 1, high from accept until done.
- done, output, 1, one-cycle completion pulse.
- timeout, output, 1, valid with done; no response start bit was seen.
- resp_o, output, RESP_SIZE, captured response, right-aligned (last received bit in bit 0, unused upper bits 0).
- crc_err, output, 1, valid with done (see Optional Feature).

Behaviour:
- Reset / sd_en low:
  - Values: cmd_o=1, cmd_oe=0, busy=0, done=0, timeout=0, resp_o=0, crc_err=0, state IDLE.
  - rst acts asynchronously; sd_en low acts at the next edge and aborts any transfer with no done pulse.
- cmd_i is registered once (cmd_q, reset value 1) before use; response latency figures include this stage.
- CRC7: polynomial x^7+x^3+1, register init 0, computed over frame bits 47..8. For CMD0 with arg 0 the frame is 0x40_0000_0000_95.
- States: IDLE, SEND, TURN, WAIT_RESP, RECV, FINISH.
- IDLE:
  - start=1 at edge k: latch cmd_idx, cmd_arg and resp_type, build the frame, set busy=1, go to SEND.
  - start while busy is ignored (no queueing).
- SEND:
  - cmd_oe=1; frame bit 47 is driven at edge k+1, then MSB first, one bit per cycle.
  - The end bit (bit 0) is driven during cycle k+48.
  - resp_type=0: go to FINISH.
  - Otherwise go to TURN.
- TURN:
  - cmd_oe=0, cmd_o=1 for TURN_CYC cycles, then WAIT_RESP.
  - Latency counter is cleared.
- WAIT_RESP:
  - cmd_q=0 means a start bit: go to RECV, with that 0 stored as the response MSB.
  - Otherwise the counter increments.
  - Counter reaching MAXLAT: set timeout=1, leave resp_o unchanged, go to FINISH.
- RECV:
  - Shift cmd_q in until 48 bits (resp_type 1/3) or 136 bits (resp_type 2) including the start bit are held.
  - Then resp_o is updated in one write and the state goes to FINISH.
  - Line activity during RECV is never interpreted as a new start.
- FINISH:
  - done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
  - timeout and crc_err hold until the next accept.
  - A new start is accepted on the cycle after done.
- Timing: no-response command gives done at edge k+49. busy=1 spans edges k+1..k+48 inclusive.
- Boundary cases:
  - Start bit seen on the last counted cycle (counter=MAXLAT-1): the response is accepted.
  - Response end bit is not checked unless the feature is enabled.

Optional Feature:
- Macro: SDIO_RESP_CRC_CHECK_EN.
- When defined, at FINISH of a received response crc_err=1 if either check fails:
  - The recomputed CRC7 does not match the received CRC (48-bit: bits 47..8 vs 7..1; 136-bit: bits 127..8 vs 7..1).
  - The end bit is not 1.
- Exception: resp_type=3 (R3-style) skips the CRC comparison and only checks the end bit.
- When undefined, crc_err is tied to 0 and no checker logic is built.

Test Plan:
- CMD0, arg 0x00000000, resp_type 0 -> cmd_o sequence equals 0x400000000095 MSB first with cmd_oe=1 for exactly 48 cycles; done at k+49, timeout=0.
- CMD8, arg 0x000001AA, resp_type 1; card returns 0x08000001AA13 after 5 idle cycles -> frame ends 0x87; resp_o[47:0]=0x08000001AA13, crc_err=0.
- CMD2, resp_type 2; card returns a 136-bit R2 after 10 idle cycles -> resp_o holds all 136 bits in order; done exactly once.
- CMD17, resp_type 1; cmd_i held 1 -> done with timeout=1 at MAXLAT cycles after TURN; resp_o unchanged.
- Abort: assert rst mid-SEND (bit 20) -> cmd_oe=0 and cmd_o=1 immediately, no done. Repeat with sd_en=0: no done. A subsequent start produces a full clean frame.
- With SDIO_RESP_CRC_CHECK_EN: CMD8 response with the CRC byte corrupted to 0x15 -> crc_err=1 with done. Without the macro: crc_err=0.
